// File: rtl/dma_fifo_drain.sv
// dma_fifo_drain
//
// DMA write engine that empties the read side of the DMA FIFO into memory.
// A start pulse loads a byte base address and a word count. The engine then
// pops one word from a first-word-fall-through FIFO. It issues one memory
// write for that word and moves to the next consecutive word address. After
// the last write it pulses done_o for one cycle.
//
// Handshakes:
//   FIFO side   - fifo_data_i is valid whenever fifo_empty_i=0.
//                 fifo_pop_o=1 consumes the head word at the rising edge.
//                 fifo_pop_o is only raised when fifo_empty_i=0.
//   memory side - mem_req_o/mem_addr_o/mem_wdata_o are held stable until a
//                 rising edge that sees mem_req_o=1 and mem_gnt_i=1. That
//                 edge completes the write. mem_gnt_i has no effect unless
//                 mem_req_o=1.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           start pulse (only honoured while idle)
//   base_addr_i       first byte address, captured with start_i
//   len_i             word count, captured with start_i (0 = empty transfer)
//   busy_o            high whenever the engine is not idle
//   done_o            one-cycle pulse at the end of a transfer
//   fifo_data_i       FIFO head word
//   fifo_empty_i      FIFO empty flag
//   fifo_pop_o        FIFO pop strobe
//   mem_req_o         memory write request
//   mem_addr_o        memory write byte address
//   mem_wdata_o       memory write data
//   mem_gnt_i         memory grant
module dma_fifo_drain #(
  parameter int C_WIDTH      = 64,
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_LEN_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [C_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [C_LEN_WIDTH-1:0]  len_i,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic [C_WIDTH-1:0]      fifo_data_i,
  input  logic                    fifo_empty_i,
  output logic                    fifo_pop_o,
  output logic                    mem_req_o,
  output logic [C_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [C_WIDTH-1:0]      mem_wdata_o,
  input  logic                    mem_gnt_i
);

  // Byte distance between consecutive words.
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_STEP = C_ADDR_WIDTH'(C_WIDTH / 8);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_REQ   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic [C_ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [C_LEN_WIDTH-1:0]  remaining, remaining_nxt;
  logic [C_WIDTH-1:0]      wdata, wdata_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      wdata     <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= remaining_nxt;
      wdata     <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    wdata_nxt     = wdata;
    fifo_pop_o    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            addr_nxt      = base_addr_i;
            remaining_nxt = len_i;
            state_nxt     = S_FETCH;
          end else begin
            // Empty transfer: report completion without touching FIFO or bus.
            state_nxt = S_DONE;
          end
        end
      end

      S_FETCH: begin
        // The FIFO is fall-through, so the head word is captured on the same
        // edge that pops it.
        if (!fifo_empty_i) begin
          fifo_pop_o = 1'b1;
          wdata_nxt  = fifo_data_i;
          state_nxt  = S_REQ;
        end
      end

      S_REQ: begin
        if (mem_gnt_i) begin
          addr_nxt      = addr + ADDR_STEP;
          remaining_nxt = remaining - C_LEN_WIDTH'(1);
          state_nxt     = (remaining == C_LEN_WIDTH'(1)) ? S_DONE : S_FETCH;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // All status and bus outputs are decoded from registered state. They drop
  // to their idle values on the cycle after a reset.
  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_DONE);
  assign mem_req_o   = (state == S_REQ);
  assign mem_addr_o  = addr;
  assign mem_wdata_o = wdata;

endmodule

// File: tb/tb_dma_fifo_drain.sv
module tb_dma_fifo_drain;

  localparam int W  = 64;
  localparam int AW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [LW-1:0] len_i;
  logic          busy_o;
  logic          done_o;
  logic [W-1:0]  fifo_data_i;
  logic          fifo_empty_i;
  logic          fifo_pop_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic [W-1:0]  mem_wdata_o;
  logic          mem_gnt_i;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dma_fifo_drain #(.C_WIDTH(W), .C_ADDR_WIDTH(AW), .C_LEN_WIDTH(LW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fifo_data_i (fifo_data_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_pop_o  (fifo_pop_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_gnt_i   (mem_gnt_i)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]    fifo_q[$];  // behavioural FIFO contents, head at [0]
  logic [AW+W-1:0] exp_q[$];   // expected writes {addr, data} in order

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present the FIFO head; garbage data while empty must never be written.
  task automatic fifo_refresh();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = fifo_empty_i ? {2{32'hdeadbeef}} : fifo_q[0];
  endtask

  // ---------------- driver ----------------
  // gnt_mode: 0 always granted, 1 five-cycle stall per request, 2 random, 3 never.
  // push_gap: 0 preloads every word, otherwise one word pushed every push_gap cycles.
  // exp_done: expected cycle of the done pulse counted from the start edge, or -1.
  task automatic run_xfer(input logic [AW-1:0] base, input int len, input int gnt_mode,
                          input int push_gap, input int exp_done, input bit seq_data,
                          input bit mid_start, input bit abort);
    logic [W-1:0] words[$];
    int  pushed, pop_cnt, wr_cnt, stall, gap_cnt, done_cyc;
    bit  pop_now, done_seen;
    exp_q.delete();
    words.delete();
    for (int i = 0; i < len; i++) begin
      logic [W-1:0] w;
      w = seq_data ? W'((i + 1) * 'h11) : {$urandom(), $urandom()};
      words.push_back(w);
      // Consecutive word addresses, wrapping at the address width.
      exp_q.push_back({base + AW'(i * (W / 8)), w});
    end
    pushed = 0;
    if (push_gap == 0) begin
      foreach (words[i]) fifo_q.push_back(words[i]);
      pushed = len;
    end
    fifo_refresh();

    start_i     = 1'b1;
    base_addr_i = base;
    len_i       = LW'(len);
    mem_gnt_i   = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;

    pop_now = 0; done_seen = 0; done_cyc = -1;
    stall = 0; gap_cnt = 0; pop_cnt = 0; wr_cnt = 0;
    for (int cyc = 1; cyc <= 3000 && !done_seen; cyc++) begin
      if (push_gap > 0 && pushed < len) begin
        gap_cnt++;
        if (gap_cnt >= push_gap) begin
          fifo_q.push_back(words[pushed]);
          pushed++;
          gap_cnt = 0;
        end
      end
      fifo_refresh();
      case (gnt_mode)
        0: mem_gnt_i = 1'b1;
        1: begin
          if (mem_req_o && stall < 5) begin
            mem_gnt_i = 1'b0;
            stall++;
          end else begin
            mem_gnt_i = 1'b1;
            stall = 0;
          end
        end
        2:       mem_gnt_i = 1'($urandom_range(0, 1));
        default: mem_gnt_i = 1'b0;
      endcase
      if (mid_start) begin
        start_i     = (cyc == 4 || cyc == 5);
        base_addr_i = 32'hdead0000;
        len_i       = 16'd7;
      end

      @(negedge clk);
      check_eq("busy_in_xfer", busy_o, 1);
      if (fifo_pop_o) begin
        check_eq("pop_nonempty", fifo_empty_i, 0);
        pop_now = 1;
        pop_cnt++;
      end
      if (mem_req_o) begin
        check_eq("req_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check_eq("wr_addr", mem_addr_o, exp_q[0][AW+W-1:W]);
          check_eq("wr_data", mem_wdata_o, exp_q[0][W-1:0]);
          if (mem_gnt_i) begin
            void'(exp_q.pop_front());
            wr_cnt++;
          end
        end
        if (abort) begin
          rst_i = 1'b1;
          @(posedge clk); #1;
          rst_i = 1'b0;
          fifo_q.delete();
          fifo_refresh();
          mem_gnt_i = 1'b0;
          @(negedge clk);
          check_eq("rst_req", mem_req_o, 0);
          check_eq("rst_busy", busy_o, 0);
          check_eq("rst_done", done_o, 0);
          check_eq("rst_pop", fifo_pop_o, 0);
          check_eq("rst_addr", mem_addr_o, 0);
          check_eq("rst_wdata", mem_wdata_o, 0);
          check_eq("rst_pops_before", pop_cnt, 1);
          @(posedge clk); #1;
          return;
        end
      end
      if (done_o) begin
        done_seen = 1;
        done_cyc  = cyc;
        check_eq("done_all_written", exp_q.size(), 0);
      end
      @(posedge clk); #1;
      if (pop_now) begin
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        pop_now = 0;
      end
    end

    check_eq("done_seen", done_seen, 1);
    if (exp_done > 0) check_eq("done_cycle", done_cyc, exp_done);
    fifo_refresh();
    mem_gnt_i = 1'b0;
    @(negedge clk);
    check_eq("done_one_cycle", done_o, 0);
    check_eq("idle_after_done", busy_o, 0);
    check_eq("no_req_idle", mem_req_o, 0);
    check_eq("pop_count", pop_cnt, len);
    check_eq("write_count", wr_cnt, len);
    check_eq("fifo_drained", fifo_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_i       = 1'b1;
    start_i     = 1'b0;
    base_addr_i = '0;
    len_i       = '0;
    mem_gnt_i   = 1'b0;
    fifo_refresh();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_eq("reset_busy", busy_o, 0);
    check_eq("reset_done", done_o, 0);
    check_eq("reset_pop", fifo_pop_o, 0);
    check_eq("reset_req", mem_req_o, 0);
    check_eq("reset_addr", mem_addr_o, 0);
    check_eq("reset_wdata", mem_wdata_o, 0);
    @(posedge clk); #1;

    // basic: 4 words, done in cycle 2N+1
    run_xfer(32'h0000_1000, 4, 0, 0, 9, 1, 0, 0);
    // backpressure: five-cycle grant stall per request
    run_xfer(32'h0000_2000, 4, 1, 0, -1, 1, 0, 0);
    // starvation: FIFO starts empty, one word every 7 cycles
    run_xfer(32'h0000_3000, 3, 0, 7, -1, 0, 0, 0);
    // zero length: done in cycle 1, nothing popped or written
    run_xfer(32'h0000_4000, 0, 0, 0, 1, 0, 0, 0);
    // start pulsed mid-transfer is ignored
    run_xfer(32'h0000_5000, 5, 0, 0, 11, 0, 1, 0);
    // address wrap
    run_xfer(32'hFFFF_FFF8, 2, 0, 0, 5, 0, 0, 0);
    // reset while a request is stalled, then a fresh basic transfer
    run_xfer(32'h0000_6000, 3, 3, 0, -1, 0, 0, 1);
    run_xfer(32'h0000_1000, 4, 0, 0, 9, 1, 0, 0);
    // randomized transfers
    for (int t = 0; t < 8; t++) begin
      run_xfer({$urandom()} & 32'hFFFF_FFF8, $urandom_range(1, 8), 2,
               ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0, -1, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_fifo_drain.md
# dma_fifo_drain

DMA write engine that drains the read side of the DMA FIFO into memory. When started with a base address and a word count, it pops words from a first-word-fall-through FIFO. It issues one memory write request per word at consecutive byte addresses using a req/gnt handshake, then pulses done. It sits between the DMA FIFO's pop port and the memory/bus write port.

## Interface
- C_WIDTH, 64, data word width in bits; must match the FIFO width; multiple of 8
- C_ADDR_WIDTH, 32, byte address width
- C_LEN_WIDTH, 16, width of the word-count field
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  start pulse; sampled only in IDLE
- base_addr_i  in  C_ADDR_WIDTH  first byte address; sampled with start_i
- len_i  in  C_LEN_WIDTH  number of words to transfer; sampled with start_i
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at transfer end
- fifo_data_i  in  C_WIDTH  FIFO head word, valid whenever fifo_empty_i=0
- fifo_empty_i  in  1  FIFO empty flag
- fifo_pop_o  out  1  pop strobe; consumes the head word at this edge
- mem_req_o  out  1  write request
- mem_addr_o  out  C_ADDR_WIDTH  write byte address
- mem_wdata_o  out  C_WIDTH  write data
- mem_gnt_i  in  1  grant; a write completes on an edge where req=1 and gnt=1

## Operation
- Registers: state, addr (C_ADDR_WIDTH), remaining (C_LEN_WIDTH), wdata (C_WIDTH).
- IDLE: on start_i with len_i≠0, load addr=base_addr_i and remaining=len_i, then go to FETCH. On start_i with len_i=0, go to DONE; no pop, no request.
- FETCH: when fifo_empty_i=0, latch wdata=fifo_data_i, assert fifo_pop_o combinationally in this cycle, and go to REQ. If empty, stay; fifo_pop_o=0.
- REQ: mem_req_o=1, mem_addr_o=addr, mem_wdata_o=wdata. addr and wdata stay stable until grant.
  - On mem_gnt_i: addr += C_WIDTH/8 (wraps modulo 2^C_ADDR_WIDTH) and remaining -= 1.
  - If remaining was 1, go to DONE; otherwise go to FETCH.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- fifo_pop_o is asserted only in FETCH with fifo_empty_i=0. It never pops an empty FIFO and pops exactly len words per transfer.
- start_i outside IDLE is ignored; no queuing.
- mem_gnt_i outside REQ is ignored.

## Timing
- Reset values: state=IDLE, busy_o=0, done_o=0, fifo_pop_o=0, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0; internal registers 0.
- Reset mid-transfer: the next cycle is IDLE with all outputs at reset values. An outstanding request is dropped. FIFO contents are not touched beyond pops already issued.
- mem_addr_o and mem_wdata_o show their registers in all states; they are meaningful only while mem_req_o=1.
- Latency: start at edge 0 (FIFO non-empty, gnt tied high):
  - FETCH cycle 1 (pop)
  - REQ cycle 2 (granted)
  - next word FETCH cycle 3
- Peak throughput is 1 word per 2 cycles.
- N words with gnt high and FIFO never empty: done_o pulses in cycle 2N+1 after start; busy_o falls the cycle after.
- len=0: DONE in cycle 1, done_o=1, no pop or request.
- Empty stall: FETCH holds with no pop. The word arriving in the FIFO is popped in the first cycle fifo_empty_i=0.
- Grant stall: REQ holds mem_req_o, addr and data unchanged indefinitely.

## Test plan
- Basic: FIFO preloaded with 0x11,0x22,0x33,0x44; start base=0x1000, len=4; gnt=1 -> writes (0x1000,0x11), (0x1008,0x22), (0x1010,0x33), (0x1018,0x44); exactly 4 pops; done_o one-cycle pulse in cycle 9; FIFO empty after.
- Backpressure: gnt held low 5 cycles per request -> mem_req_o, addr and data stable through each stall; no extra pops; same write sequence.
- Starvation: FIFO empty at start, one word pushed every 7 cycles, len=3 -> no pop while empty; 3 writes in order; done after third grant.
- Zero length and ignored start: len=0 -> done_o pulse next cycle, no req or pop. start_i pulsed mid-transfer with different base and len -> no effect on the current transfer.
- Wrap: C_ADDR_WIDTH=32, base=0xFFFFFFF8, len=2 -> addresses 0xFFFFFFF8 then 0x00000000.
- Reset mid-operation: rst_i asserted while in REQ with gnt=0 -> next cycle mem_req_o=0 and busy_o=0. A fresh start then behaves as in the basic test.
